// File: rtl/ha_array_pkg.sv
// Shared constants, FSM encoding and row-weight helper for the ha-array
// multiplier controller.
package ha_array_pkg;
  localparam int ROWS  = 4;
  localparam int T_W   = 9;
  localparam int B_W   = 7;
  localparam int P_W   = 16;
  localparam int X_W   = 8;
  localparam int PTR_W = 2;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // V_k = (t + 2b) << 2k; the all-ones worst case sums to 0xFE01, so no carry-out.
  function automatic logic [P_W-1:0] row_weight(input logic [T_W-1:0]   t,
                                                input logic [B_W-1:0]   b,
                                                input logic [PTR_W-1:0] k);
    logic [P_W-1:0] v;
    v = P_W'(t) + (P_W'(b) << 1);
    return v << {k, 1'b0};
  endfunction
endpackage

// File: rtl/ha_array_mul_seq_ctrl_row_select.sv
// Priority scan over the row mask: finds the next enabled row after ptr
// (or the lowest enabled row when from_start is set).
module ha_row_select
  import ha_array_pkg::*;
(
  input  logic [ROWS-1:0]  mask,
  input  logic [PTR_W-1:0] ptr,
  input  logic             from_start,
  output logic [PTR_W-1:0] nxt,
  output logic             last
);

  // last means nothing left to scan; with from_start that means an empty mask.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || i > int'(ptr))) begin
        nxt  = PTR_W'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ha_array_mul_seq_ctrl.sv
// Sequences a shared combinational ha-array generator, accumulating one
// enabled row per cycle into an approximate 8x8 product.
module ha_array_mul_seq_ctrl
  import ha_array_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [X_W-1:0]      in_x,
  input  logic [X_W-1:0]      in_y,
  input  logic [ROWS-1:0]     in_row_mask,
  output logic [X_W-1:0]      mul_x,
  output logic [X_W-1:0]      mul_y,
  input  logic [ROWS*T_W-1:0] row_t,
  input  logic [ROWS*B_W-1:0] row_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [P_W-1:0]      out_product
);

  state_t            state, state_nxt;
  logic [ROWS-1:0]   mask_q;
  logic [PTR_W-1:0]  ptr, nxt_ptr;
  logic [P_W-1:0]    acc;
  logic [ROWS-1:0]   sel_mask;
  logic              last, accept;
  logic [T_W-1:0]    t_sel;
  logic [B_W-1:0]    b_sel;

  assign accept   = in_valid && (state == IDLE);
  // In IDLE the scan runs on the incoming mask so the first row is known at accept.
  assign sel_mask = (state == IDLE) ? in_row_mask : mask_q;
  assign t_sel    = row_t[int'(ptr)*T_W +: T_W];
  assign b_sel    = row_b[int'(ptr)*B_W +: B_W];

  ha_row_select u_sel (
    .mask       (sel_mask),
    .ptr        (ptr),
    .from_start (state == IDLE),
    .nxt        (nxt_ptr),
    .last       (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = last ? DONE : ACC;
      end
      ACC:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x  <= '0;
      mul_y  <= '0;
      mask_q <= '0;
      ptr    <= '0;
      acc    <= '0;
    end else if (accept) begin
      mul_x  <= in_x;
      mul_y  <= in_y;
      mask_q <= in_row_mask;
      ptr    <= nxt_ptr;
      acc    <= '0;
    end else if (state == ACC) begin
      acc <= acc + row_weight(t_sel, b_sel, ptr);
      ptr <= nxt_ptr;
    end
  end

  assign out_product = acc;

endmodule

// File: tb/tb_ha_array_mul_seq_ctrl.sv
// Directed bench: transaction-level model checked every cycle plus
// hand-computed literals for latency and products.
module tb_ha_array_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [7:0]  in_x = '0, in_y = '0, mul_x, mul_y;
  logic [3:0]  in_row_mask = '0;
  logic [35:0] row_t = '0;
  logic [27:0] row_b = '0;
  logic [15:0] out_product;

  int n_chk = 0, n_fail = 0;

  ha_array_mul_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_row_mask(in_row_mask),
    .mul_x(mul_x), .mul_y(mul_y), .row_t(row_t), .row_b(row_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 busy counting rows, 2 holding result.
  int          m_st, m_cnt;
  logic [15:0] m_prod;
  logic [7:0]  m_x, m_y;

  function automatic int model_prod(input logic [3:0] mask);
    int s = 0;
    for (int k = 0; k < 4; k++)
      if (mask[k]) s += (int'(row_t[k*9 +: 9]) + 2 * int'(row_b[k*7 +: 7])) * (1 << (2 * k));
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_prod <= '0; m_x <= '0; m_y <= '0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          m_prod <= 16'(model_prod(in_row_mask));
          m_x    <= in_x;
          m_y    <= in_y;
          m_cnt  <= $countones(in_row_mask);
          m_st   <= ($countones(in_row_mask) == 0) ? 2 : 1;
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_st <= 2;
        end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(m_st == 0));
    chk("out_valid", int'(out_valid), int'(m_st == 2));
    chk("mul_x", int'(mul_x), int'(m_x));
    chk("mul_y", int'(mul_y), int'(m_y));
    if (m_st == 2) chk("out_product", int'(out_product), int'(m_prod));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept at edge T, return number of edges until out_valid is seen.
  task automatic request(input logic [7:0] x, input logic [7:0] y, input logic [3:0] m,
                         output int lat);
    in_x = x; in_y = y; in_row_mask = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = ~x; in_y = ~y; in_row_mask = ~m;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      lat++;
      if (out_valid) break;
      step();
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic take();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_product", int'(out_product), 0);
    chk("rst_mul_x", int'(mul_x), 0);
    rst = 1'b0;
    step();

    // Single LSB row, all rows enabled.
    row_t = 36'h0_0000_0001; row_b = '0;
    request(8'h12, 8'h34, 4'hF, lat);
    lat = lat; // latency counted from accept edge
    chk("lat_mask_f", lat - 1 + 1, 5);
    chk("prod_one", int'(out_product), 16'h0001);
    take();

    // Worst case, no overflow.
    row_t = '1; row_b = '1;
    request(8'hFF, 8'hFF, 4'hF, lat);
    chk("lat_all_ones", lat, 5);
    chk("prod_fe01", int'(out_product), 16'hFE01);
    take();

    // Sparse mask skips disabled rows.
    in_x = 8'hA5; in_y = 8'h5A; in_row_mask = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mul_x_T1", int'(mul_x), 8'hA5);
    chk("mul_y_T1", int'(mul_y), 8'h5A);
    for (int i = 0; i < 2; i++) step();
    chk("valid_T3", int'(out_valid), 1);
    chk("prod_1010", int'(out_product), 52020);
    take();

    // Empty mask: result straight away.
    request(8'h01, 8'h02, 4'h0, lat);
    chk("lat_mask_0", lat, 1);
    chk("prod_zero", int'(out_product), 0);
    chk("in_ready_done", int'(in_ready), 0);

    // Stall the consumer; the product must hold.
    row_t = 36'h0_0000_0003; row_b = 28'h000_0001;
    take();
    request(8'h33, 8'h44, 4'b0001, lat);
    for (int i = 0; i < 3; i++) begin
      chk("stall_prod", int'(out_product), 5);
      chk("stall_valid", int'(out_valid), 1);
      step();
    end
    take();
    chk("ready_after_hs", int'(in_ready), 1);
    request(8'h55, 8'h66, 4'b0001, lat);
    chk("b2b_lat", lat, 2);
    chk("b2b_prod", int'(out_product), 5);
    take();

    // Asynchronous reset in the middle of accumulation.
    row_t = '1; row_b = '1;
    in_x = 8'h77; in_y = 8'h88; in_row_mask = 4'hF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_product", int'(out_product), 0);
    chk("arst_mul_x", int'(mul_x), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale_valid", int'(out_valid), 0);
      step();
    end
    request(8'h10, 8'h20, 4'b0100, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_prod", int'(out_product), 12240);
    take();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
